// File: rtl/qsfp_i2c_pkg.sv
`default_nettype none
// ============================================================================
// qsfp_i2c_pkg : state encoding and bus-level constants for the QSFP I2C master
// Revision     : 1.0
// ============================================================================
package qsfp_i2c_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START   = 4'd1,
    WR_BYTE = 4'd2,
    WR_ACK  = 4'd3,
    RESTART = 4'd4,
    RD_BYTE = 4'd5,
    RD_NACK = 4'd6,
    STOP    = 4'd7,
    DONE    = 4'd8
  } state_t;

  localparam logic c_rw_write = 1'b0;
  localparam logic c_rw_read  = 1'b1;
  localparam logic c_ack      = 1'b0;
  localparam logic c_nack     = 1'b1;

endpackage
`default_nettype wire

// File: rtl/qsfp_i2c_qtimer.sv
`default_nettype none
// ============================================================================
// qsfp_i2c_qtimer : quarter-phase tick and phase index; SCL-high stall when
//                   QSFP_I2C_CLK_STRETCH_EN is defined
// Revision        : 1.0
// ============================================================================
module qsfp_i2c_qtimer #(
  parameter int CLK_DIV = 250
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       run,
  input  logic       scl_sync,
  output logic       tick,
  output logic [1:0] phase
);

`ifdef QSFP_I2C_CLK_STRETCH_EN
  localparam logic c_stretch_en = 1'b1;
`else
  localparam logic c_stretch_en = 1'b0;
`endif
  localparam logic [15:0] c_last = 16'(CLK_DIV - 1);

  logic [15:0] r_cnt;
  logic [1:0]  r_phase;
  logic        w_stall;

  // Phase 2 is the first SCL-high quarter; a slave holding SCL low freezes it.
  assign w_stall = c_stretch_en && (r_phase == 2'd2) && !scl_sync;
  assign tick    = run && !w_stall && (r_cnt == c_last);
  assign phase   = r_phase;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt   <= 16'd0;
      r_phase <= 2'd0;
    end else if (!run) begin
      r_cnt   <= 16'd0;
      r_phase <= 2'd0;
    end else if (tick) begin
      r_cnt   <= 16'd0;
      r_phase <= r_phase + 2'd1;
    end else if (!w_stall) begin
      r_cnt   <= r_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/qsfp_i2c_master.sv
`default_nettype none
// ============================================================================
// qsfp_i2c_master : single-register I2C write / random read master for QSFP
//                   management; clock stretching via QSFP_I2C_CLK_STRETCH_EN
// Revision        : 1.0
// ============================================================================
module qsfp_i2c_master
  import qsfp_i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       io_control_pulse,
  input  logic       io_control_rw,
  input  logic [7:0] io_control_id,
  input  logic [7:0] io_addr_addr,
  input  logic [7:0] io_wdata_wdata,
  output logic [7:0] io_rdata_rdata,
  output logic       io_control_cmplt,
  output logic       ack_err,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  state_t      r_state, w_next;
  logic [1:0]  r_scl_sync, r_sda_sync;
  logic        w_scl_s, w_sda_s;
  logic        r_rw, r_nack, r_ack_err;
  logic [7:0]  r_id_rd, r_addr, r_wdata, r_shift, r_rdata;
  logic [2:0]  r_bit;
  logic [1:0]  r_byte;
  logic        r_scl_oe, r_sda_oe;
  logic        w_run, w_tick, w_end, w_accept;
  logic [1:0]  w_phase;
  logic        w_scl_low, w_sda_low;

  assign w_scl_s  = r_scl_sync[1];
  assign w_sda_s  = r_sda_sync[1];
  assign w_accept = (r_state == IDLE) && io_control_pulse;
  assign w_run    = (r_state != IDLE) && (r_state != DONE);
  assign w_end    = w_tick && (w_phase == 2'd3);

  assign io_rdata_rdata = r_rdata;
  assign ack_err        = r_ack_err;
  assign scl_oe         = r_scl_oe;
  assign sda_oe         = r_sda_oe;

  qsfp_i2c_qtimer #(.CLK_DIV(CLK_DIV)) u_qtimer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .run      (w_run),
    .scl_sync (w_scl_s),
    .tick     (w_tick),
    .phase    (w_phase)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (io_control_pulse) w_next = START;
      START:   if (w_end) w_next = WR_BYTE;
      WR_BYTE: if (w_end && (r_bit == 3'd7)) w_next = WR_ACK;
      WR_ACK: begin
        if (w_end) begin
          if (w_sda_s == c_nack)                        w_next = STOP;
          else if ((r_byte == 2'd1) && (r_rw == c_rw_read)) w_next = RESTART;
          else if (r_byte == 2'd2)
            w_next = (r_rw == c_rw_read) ? RD_BYTE : STOP;
          else                                          w_next = WR_BYTE;
        end
      end
      RESTART: if (w_end) w_next = WR_BYTE;
      RD_BYTE: if (w_end && (r_bit == 3'd7)) w_next = RD_NACK;
      RD_NACK: if (w_end) w_next = STOP;
      STOP:    if (w_end) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // SDA only moves in phases 1..3; phase 0 holds the previous level while SCL falls.
  always_comb begin
    w_scl_low        = 1'b0;
    w_sda_low        = r_sda_oe;
    busy             = (r_state != IDLE);
    io_control_cmplt = (r_state == DONE);
    case (r_state)
      START: w_sda_low = w_phase[1];
      RESTART: begin
        w_scl_low = (w_phase == 2'd0);
        if (w_phase != 2'd0) w_sda_low = w_phase[1];
      end
      WR_BYTE: begin
        w_scl_low = !w_phase[1];
        if (w_phase != 2'd0) w_sda_low = ~r_shift[7];
      end
      WR_ACK, RD_BYTE, RD_NACK: begin
        w_scl_low = !w_phase[1];
        if (w_phase != 2'd0) w_sda_low = 1'b0;
      end
      STOP: begin
        w_scl_low = !w_phase[1];
        if (w_phase != 2'd0) w_sda_low = (w_phase != 2'd3);
      end
      default: w_sda_low = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_oe   <= 1'b0;
      r_sda_oe   <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
      r_scl_oe   <= w_scl_low;
      r_sda_oe   <= w_sda_low;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rw      <= c_rw_write;
      r_id_rd   <= 8'h00;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_shift   <= 8'h00;
      r_rdata   <= 8'h00;
      r_bit     <= 3'd0;
      r_byte    <= 2'd0;
      r_nack    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rw      <= io_control_rw;
        r_id_rd   <= io_control_id | {7'd0, c_rw_read};
        r_addr    <= io_addr_addr;
        r_wdata   <= io_wdata_wdata;
        r_shift   <= {io_control_id[7:1], c_rw_write};
        r_bit     <= 3'd0;
        r_byte    <= 2'd0;
        r_nack    <= 1'b0;
        r_ack_err <= 1'b0;
      end
      case (r_state)
        WR_BYTE: if (w_end) begin
          r_shift <= {r_shift[6:0], 1'b0};
          r_bit   <= r_bit + 3'd1;
        end
        RD_BYTE: if (w_end) begin
          r_shift <= {r_shift[6:0], w_sda_s};
          r_bit   <= r_bit + 3'd1;
        end
        WR_ACK: if (w_end) begin
          if (w_sda_s == c_nack) begin
            r_nack <= 1'b1;
          end else if (r_byte == 2'd0) begin
            r_shift <= r_addr;
            r_byte  <= 2'd1;
          end else if ((r_byte == 2'd1) && (r_rw == c_rw_write)) begin
            r_shift <= r_wdata;
            r_byte  <= 2'd2;
          end
        end
        RESTART: if (w_end) begin
          r_shift <= r_id_rd;
          r_byte  <= 2'd2;
        end
        // Results are published on entry to DONE so they are valid alongside cmplt.
        STOP: if (w_end) begin
          r_ack_err <= r_nack;
          if ((r_rw == c_rw_read) && !r_nack) r_rdata <= r_shift;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
